sd_sector_reader: RTL and testbench

- SPI-mode SD single-block read engine. It is the responder for the sector-read requester: it accepts a rd_start_en pulse plus rd_sec_addr and issues CMD17.
- It collects the 512-byte block from the card and streams it out as 256 16-bit words into the downstream read FIFO (16w32r).
- rd_busy falls when the block is complete; the requester uses that edge to advance to the next sector.
- The SD SPI clock is generated outside this block as the inverted clk, so each clk cycle carries one SPI bit.

---
 rtl/sd_sector_reader.sv | 201 ++++++++++++++++++++
 tb/tb_sd_sector_reader.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_reader.sv
// SPI-mode SD single-block reader: issues CMD17, waits for R1 and the
// data token, then streams the 512-byte block out as 256 16-bit words.
module sd_sector_reader #(
  parameter int ADDR_IS_BLOCK = 1,
  parameter int RESP_TIMEOUT  = 255,
  parameter int TOKEN_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_init_done,
  input  logic        rd_start_en,
  input  logic [31:0] rd_sec_addr,
  output logic        rd_busy,
  output logic        rd_val_en,
  output logic [15:0] rd_val_data,
  output logic        rd_err,
  output logic        sd_cs,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_R1,
    S_RECV_R1,
    S_WAIT_TOKEN,
    S_RD_DATA,
    S_RD_CRC,
    S_FINISH
  } state_t;

  localparam logic [15:0] LP_RESP_LAST  = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0] LP_TOKEN_LAST = 16'(TOKEN_TIMEOUT - 1);

  state_t      r_state;
  logic [47:0] r_cmd;
  logic [15:0] r_cnt;
  logic [7:0]  r_sh8;
  logic [15:0] r_word;
  logic [3:0]  r_bit;
  logic [7:0]  r_wcnt;
  logic        r_val_en;
  logic [15:0] r_val_data;
  logic        r_err;

  state_t      w_state_n;
  logic [47:0] w_cmd_n;
  logic [15:0] w_cnt_n;
  logic [7:0]  w_sh8_n;
  logic [15:0] w_word_n;
  logic [3:0]  w_bit_n;
  logic [7:0]  w_wcnt_n;
  logic        w_val_en_n;
  logic [15:0] w_val_data_n;
  logic        w_err_n;

  logic [31:0] w_arg;
  logic [7:0]  w_sh8_in;
  logic [15:0] w_word_in;

  // SDSC cards take a byte address; the shift drops the top 9 bits
  assign w_arg = (ADDR_IS_BLOCK != 0) ? rd_sec_addr
                                      : {rd_sec_addr[22:0], 9'd0};
  assign w_sh8_in  = {r_sh8[6:0], sd_miso};
  assign w_word_in = {r_word[14:0], sd_miso};

  assign rd_busy     = (r_state != S_IDLE);
  assign sd_cs       = (r_state == S_IDLE);
  assign sd_mosi     = (r_state == S_SEND_CMD) ? r_cmd[47] : 1'b1;
  assign rd_val_en   = r_val_en;
  assign rd_val_data = r_val_data;
  assign rd_err      = r_err;

  always_comb begin
    w_state_n    = r_state;
    w_cmd_n      = r_cmd;
    w_cnt_n      = r_cnt;
    w_sh8_n      = r_sh8;
    w_word_n     = r_word;
    w_bit_n      = r_bit;
    w_wcnt_n     = r_wcnt;
    w_val_en_n   = 1'b0;
    w_val_data_n = r_val_data;
    w_err_n      = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (rd_start_en && sd_init_done) begin
          w_state_n = S_SEND_CMD;
          w_cmd_n   = {8'h51, w_arg, 8'hFF};
          w_cnt_n   = '0;
          w_err_n   = 1'b0;
        end
      end
      S_SEND_CMD: begin
        w_cmd_n = {r_cmd[46:0], 1'b1};
        w_cnt_n = r_cnt + 16'd1;
        if (r_cnt == 16'd47) begin
          w_state_n = S_WAIT_R1;
          w_cnt_n   = '0;
        end
      end
      S_WAIT_R1: begin
        w_cnt_n = r_cnt + 16'd1;
        if (!sd_miso) begin
          w_state_n = S_RECV_R1;
          w_cnt_n   = '0;
          w_sh8_n   = '0;
        end else if (r_cnt == LP_RESP_LAST) begin
          w_state_n = S_FINISH;
          w_cnt_n   = '0;
          w_err_n   = 1'b1;
        end
      end
      S_RECV_R1: begin
        w_sh8_n = w_sh8_in;
        w_cnt_n = r_cnt + 16'd1;
        if (r_cnt == 16'd6) begin
          w_cnt_n = '0;
          // idle-high preload so R1 zeros cannot fake a token
          w_sh8_n = 8'hFF;
          if (w_sh8_in == 8'h00) begin
            w_state_n = S_WAIT_TOKEN;
          end else begin
            w_state_n = S_FINISH;
            w_err_n   = 1'b1;
          end
        end
      end
      S_WAIT_TOKEN: begin
        w_sh8_n = w_sh8_in;
        w_cnt_n = r_cnt + 16'd1;
        if (w_sh8_in == 8'hFE) begin
          w_state_n = S_RD_DATA;
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_wcnt_n  = '0;
        end else if (r_cnt == LP_TOKEN_LAST) begin
          w_state_n = S_FINISH;
          w_cnt_n   = '0;
          w_err_n   = 1'b1;
        end
      end
      S_RD_DATA: begin
        w_word_n = w_word_in;
        w_bit_n  = r_bit + 4'd1;
        if (r_bit == 4'd15) begin
          w_val_en_n   = 1'b1;
          w_val_data_n = w_word_in;
          w_wcnt_n     = r_wcnt + 8'd1;
          if (r_wcnt == 8'd255) begin
            w_state_n = S_RD_CRC;
            w_cnt_n   = '0;
          end
        end
      end
      S_RD_CRC: begin
        w_cnt_n = r_cnt + 16'd1;
        if (r_cnt == 16'd15) begin
          w_state_n = S_FINISH;
          w_cnt_n   = '0;
        end
      end
      S_FINISH: begin
        w_cnt_n = r_cnt + 16'd1;
        if (r_cnt == 16'd7) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_cnt      <= '0;
      r_sh8      <= '0;
      r_word     <= '0;
      r_bit      <= '0;
      r_wcnt     <= '0;
      r_val_en   <= 1'b0;
      r_val_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cmd      <= w_cmd_n;
      r_cnt      <= w_cnt_n;
      r_sh8      <= w_sh8_n;
      r_word     <= w_word_n;
      r_bit      <= w_bit_n;
      r_wcnt     <= w_wcnt_n;
      r_val_en   <= w_val_en_n;
      r_val_data <= w_val_data_n;
      r_err      <= w_err_n;
    end
  end

endmodule

// File: tb/tb_sd_sector_reader.sv
// Directed bench for sd_sector_reader with a bit-level SD card model.
// Two instances cover block and byte addressing.
module tb_sd_sector_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        miso = 1'b1;
  logic [31:0] addr = '0;

  logic        busy_a, ve_a, err_a, cs_a, mosi_a;
  logic [15:0] vd_a;
  logic        busy_b, ve_b, err_b, cs_b, mosi_b;
  logic [15:0] vd_b;

  logic        sel_b = 1'b0;
  logic        busy_s, ve_s, cs_s, mosi_s;
  logic [15:0] vd_s;

  int          tests = 0;
  int          fails = 0;
  logic [47:0] frame = '0;
  int          ncs = 0;
  bit          q[$];
  logic [15:0] words[256];
  int          wcnt = 0;

  always #5 clk = ~clk;

  sd_sector_reader #(.ADDR_IS_BLOCK(1)) dut_a (
    .clk(clk), .rst(rst), .sd_init_done(init_done),
    .rd_start_en(start_a), .rd_sec_addr(addr),
    .rd_busy(busy_a), .rd_val_en(ve_a), .rd_val_data(vd_a),
    .rd_err(err_a), .sd_cs(cs_a), .sd_mosi(mosi_a), .sd_miso(miso)
  );

  sd_sector_reader #(.ADDR_IS_BLOCK(0)) dut_b (
    .clk(clk), .rst(rst), .sd_init_done(init_done),
    .rd_start_en(start_b), .rd_sec_addr(addr),
    .rd_busy(busy_b), .rd_val_en(ve_b), .rd_val_data(vd_b),
    .rd_err(err_b), .sd_cs(cs_b), .sd_mosi(mosi_b), .sd_miso(miso)
  );

  assign busy_s = sel_b ? busy_b : busy_a;
  assign ve_s   = sel_b ? ve_b   : ve_a;
  assign vd_s   = sel_b ? vd_b   : vd_a;
  assign cs_s   = sel_b ? cs_b   : cs_a;
  assign mosi_s = sel_b ? mosi_b : mosi_a;

  // card model: capture the 48 command bits, then replay the queue
  always @(negedge clk) begin
    if (cs_s) begin
      ncs = 0;
      miso = 1'b1;
    end else begin
      ncs++;
      if (ncs <= 48) frame = {frame[46:0], mosi_s};
      if (ncs >= 49 && q.size() > 0) miso = q.pop_front();
      else miso = 1'b1;
    end
    if (ve_s) begin
      if (wcnt < 256) words[wcnt] = vd_s;
      wcnt++;
    end
  end

  function automatic void push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) q.push_back(b[i]);
  endfunction

  task automatic load_card(input int idle_bytes, input bit has_r1,
                           input logic [7:0] r1, input int gap_bytes,
                           input bit has_token);
    q.delete();
    for (int i = 0; i < idle_bytes; i++) push_byte(8'hFF);
    if (has_r1) push_byte(r1);
    for (int i = 0; i < gap_bytes; i++) push_byte(8'hFF);
    if (has_token) begin
      push_byte(8'hFE);
      for (int i = 0; i < 512; i++) push_byte(8'(i));
      push_byte(8'hA5);
      push_byte(8'h5A);
    end
  endtask

  task automatic pulse_start(input bit use_b, input logic [31:0] a);
    @(negedge clk);
    addr = a;
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int hi,
                           output int last_ve, output bit ok);
    hi = 0;
    last_ve = -1;
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (busy_s) hi++;
      if (ve_s) last_ve = hi;
      if (!busy_s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({cs_a, mosi_a, busy_a, ve_a, vd_a, err_a} !== 21'h180000) begin
      fails++;
      $display("FAIL reset_a: got %h want %h",
               {cs_a, mosi_a, busy_a, ve_a, vd_a, err_a}, 21'h180000);
    end
    tests++;
    if ({cs_b, mosi_b, busy_b, ve_b, vd_b, err_b} !== 21'h180000) begin
      fails++;
      $display("FAIL reset_b: got %h want %h",
               {cs_b, mosi_b, busy_b, ve_b, vd_b, err_b}, 21'h180000);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal;
    int hi, lv;
    bit ok;
    sel_b = 1'b0;
    load_card(2, 1'b1, 8'h00, 10, 1'b1);
    wcnt = 0;
    pulse_start(1'b0, 32'd33472);
    wait_idle(10000, hi, lv, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL normal_done: busy still high after %0d", hi);
    end
    tests++;
    if (frame !== 48'h51_000082C0_FF) begin
      fails++;
      $display("FAIL normal_frame: got %h want 51000082c0ff", frame);
    end
    tests++;
    if (wcnt != 256) begin
      fails++;
      $display("FAIL normal_count: got %0d want 256", wcnt);
    end
    tests++;
    if ({words[0], words[127], words[128], words[255]} !==
        64'h0001_FEFF_0001_FEFF) begin
      fails++;
      $display("FAIL normal_words: got %h %h %h %h want 0001 feff 0001 feff",
               words[0], words[127], words[128], words[255]);
    end
    tests++;
    if (err_a !== 1'b0) begin
      fails++;
      $display("FAIL normal_err: got %b want 0", err_a);
    end
    tests++;
    if (hi - lv != 23) begin
      fails++;
      $display("FAIL normal_tail: got %0d want 23", hi - lv);
    end
    tests++;
    if (hi != 4280) begin
      fails++;
      $display("FAIL normal_len: got %0d want 4280", hi);
    end
    tests++;
    if (cs_a !== 1'b1) begin
      fails++;
      $display("FAIL normal_cs: got %b want 1", cs_a);
    end
  endtask

  task automatic test_byte_addr;
    int hi, lv;
    bit ok;
    sel_b = 1'b1;
    load_card(0, 1'b0, 8'h00, 0, 1'b0);
    pulse_start(1'b1, 32'd33472);
    wait_idle(1000, hi, lv, ok);
    tests++;
    if (!ok || frame !== 48'h51_01058000_FF) begin
      fails++;
      $display("FAIL byte_frame: got %h ok %b want 5101058000ff", frame, ok);
    end
    tests++;
    if (err_b !== 1'b1) begin
      fails++;
      $display("FAIL byte_err: got %b want 1", err_b);
    end
    sel_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_r1_error;
    int hi, lv;
    bit ok;
    load_card(2, 1'b1, 8'h04, 10, 1'b1);
    wcnt = 0;
    pulse_start(1'b0, 32'd1);
    wait_idle(2000, hi, lv, ok);
    tests++;
    if (!ok || err_a !== 1'b1 || wcnt != 0) begin
      fails++;
      $display("FAIL r1_err: got ok %b err %b words %0d want 1 1 0",
               ok, err_a, wcnt);
    end
    tests++;
    if (hi != 80) begin
      fails++;
      $display("FAIL r1_len: got %0d want 80", hi);
    end
  endtask

  task automatic test_resp_timeout;
    int hi, lv;
    bit ok;
    load_card(0, 1'b0, 8'h00, 0, 1'b0);
    wcnt = 0;
    pulse_start(1'b0, 32'd2);
    tests++;
    if (err_a !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: got %b want 0", err_a);
    end
    wait_idle(2000, hi, lv, ok);
    tests++;
    if (!ok || err_a !== 1'b1 || wcnt != 0) begin
      fails++;
      $display("FAIL resp_to: got ok %b err %b words %0d want 1 1 0",
               ok, err_a, wcnt);
    end
    tests++;
    if (hi != 311) begin
      fails++;
      $display("FAIL resp_to_len: got %0d want 311", hi);
    end
  endtask

  task automatic test_token_timeout;
    int hi, lv;
    bit ok;
    load_card(2, 1'b1, 8'h00, 0, 1'b0);
    wcnt = 0;
    pulse_start(1'b0, 32'd3);
    wait_idle(70000, hi, lv, ok);
    tests++;
    if (!ok || err_a !== 1'b1 || wcnt != 0) begin
      fails++;
      $display("FAIL tok_to: got ok %b err %b words %0d want 1 1 0",
               ok, err_a, wcnt);
    end
    tests++;
    if (hi != 65615) begin
      fails++;
      $display("FAIL tok_to_len: got %0d want 65615", hi);
    end
  endtask

  task automatic test_init_low;
    int bad;
    bad = 0;
    init_done = 1'b0;
    pulse_start(1'b0, 32'd4);
    for (int i = 0; i < 5; i++) begin
      if (busy_a !== 1'b0 || cs_a !== 1'b1) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL init_low: got %0d busy cycles want 0", bad);
    end
    init_done = 1'b1;
  endtask

  task automatic test_reset_mid_read;
    int n0;
    load_card(2, 1'b1, 8'h00, 10, 1'b1);
    wcnt = 0;
    pulse_start(1'b0, 32'd33472);
    for (int i = 0; i < 6000 && wcnt <= 100; i++) @(negedge clk);
    tests++;
    if (wcnt <= 100) begin
      fails++;
      $display("FAIL mid_reach: got %0d words want >100", wcnt);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({cs_a, mosi_a, busy_a, ve_a, vd_a, err_a} !== 21'h180000) begin
      fails++;
      $display("FAIL mid_reset: got %h want %h",
               {cs_a, mosi_a, busy_a, ve_a, vd_a, err_a}, 21'h180000);
    end
    rst = 1'b0;
    n0 = wcnt;
    repeat (100) @(negedge clk);
    tests++;
    if (wcnt != n0 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL mid_quiet: got words %0d busy %b want %0d 0",
               wcnt, busy_a, n0);
    end
  endtask

  task automatic test_start_filter;
    int hi, lv;
    bit ok;
    load_card(2, 1'b1, 8'h00, 10, 1'b1);
    wcnt = 0;
    pulse_start(1'b0, 32'd33472);
    for (int i = 0; i < 6000 && wcnt < 50; i++) @(negedge clk);
    pulse_start(1'b0, 32'd7);
    wait_idle(10000, hi, lv, ok);
    tests++;
    if (!ok || wcnt != 256) begin
      fails++;
      $display("FAIL filt_count: got ok %b words %0d want 1 256", ok, wcnt);
    end
    tests++;
    if (words[200] !== 16'h9091 || words[255] !== 16'hFEFF) begin
      fails++;
      $display("FAIL filt_words: got %h %h want 9091 feff",
               words[200], words[255]);
    end
    tests++;
    if (err_a !== 1'b0) begin
      fails++;
      $display("FAIL filt_err: got %b want 0", err_a);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (busy_a !== 1'b0 || cs_a !== 1'b1) begin
      fails++;
      $display("FAIL filt_queue: got busy %b cs %b want 0 1", busy_a, cs_a);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_byte_addr;
    test_r1_error;
    test_resp_timeout;
    test_token_timeout;
    test_init_low;
    test_reset_mid_read;
    test_start_filter;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
